instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Sequences the program counter into the combinational instruction memory, which is word-indexed.
- Buffers fetched words in a small prefetch queue and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue.
- Sits between the PC/branch logic and decode, and is the only driver of the memory address.

Parameters:
- DEPTH, 2: prefetch queue entries; power of two, 2..8.
- NUM_INSTR, 11: instruction memory size in words; bounds the address space.
- RESET_PC, 0: first word address fetched after reset.

Ports:
- i_clk  input  1  system clock; all state changes on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  fetch enable; when 0, no new fetches are issued and the queue holds.
- o_imem_addr  output  32  word address to the instruction memory.
- i_imem_data  input  32  instruction word returned combinationally for o_imem_addr.
- i_redirect  input  1  one-cycle pulse: flush the queue and restart at i_redirect_pc.
- i_redirect_pc  input  32  target word address, sampled when i_redirect=1.
- o_instr  output  32  instruction at the queue head.
- o_instr_pc  output  32  word address of o_instr.
- o_valid  output  1  queue head is valid.
- i_ready  input  1  decode accepts the head when o_valid & i_ready.
- o_fault  output  1  fetch address out of range (feature-dependent, see below).

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, queue empty, o_valid=0, o_instr=0, o_instr_pc=0, o_fault=0, state=RUN.
- o_imem_addr = fetch_pc at all times (combinational from register).
- Fetch rule: the word is written to the tail as {i_imem_data, fetch_pc}, and fetch_pc increments by 1, when all of the following hold: state=RUN, i_en=1, i_redirect=0, and the queue is not full or a pop occurs this same cycle.
- Pop: o_valid & i_ready removes the head.
- Simultaneous push and pop on a full queue is allowed; occupancy is unchanged.
- Latency: first word is valid at the head one cycle after reset release with i_en=1. Sustained throughput is 1 instruction/cycle.
- Output timing: o_instr and o_instr_pc come from the head registers; o_valid = (count!=0).
- Full queue with no pop: no push, fetch_pc holds.
- Empty queue: o_valid=0; i_ready is ignored.
- Redirect has priority over push and pop in the same cycle:
  - the queue is cleared (count=0), so o_valid=0 the next cycle;
  - fetch_pc=i_redirect_pc; o_fault clears; state=RUN;
  - no push occurs in the redirect cycle;
  - the first redirected word is valid 2 cycles after the redirect pulse (push in cycle+1, visible in cycle+2);
  - any pop handshake in the redirect cycle is still treated as consumed by decode but has no queue effect.
- fetch_pc is 32-bit and wraps 0xFFFFFFFF->0 when the feature is compiled out.
- Queue pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- States: RUN (normal fetching), HALT (out-of-range, feature only).
  - RUN->HALT when the out-of-range condition hits.
  - HALT->RUN only on i_redirect or reset.
- Reset asserted mid-operation: all state returns to reset values immediately; queue contents are discarded.

Optional Feature:
IFETCH_BOUNDS_CHECK_EN
- Defined:
  - In RUN, if fetch_pc >= NUM_INSTR and a push would occur, do not push; go to HALT and set o_fault=1 the next cycle.
  - Words already queued still drain normally.
  - While in HALT, o_imem_addr holds the faulting address.
  - A redirect to an in-range address clears o_fault and resumes fetching.
- Undefined: no range check; o_fault is tied to 0 and the HALT state does not exist. Out-of-range addresses are passed to memory unchanged.

Test Plan:
- Reset release, i_en=1, i_ready=1, memory word at address n = 0x1000+n:
  - cycle 1: o_valid=1, o_instr=0x1000, o_instr_pc=0;
  - then one instruction per cycle with incrementing pc.
- i_ready=0 with DEPTH=2:
  - after 2 pushes the queue is full and o_imem_addr holds at 2;
  - raise i_ready: words 0,1,2 appear in order with no gap or duplicate.
- Redirect to 7 while the queue holds pcs 3,4 and i_ready=1 in the same cycle:
  - next cycle o_valid=0;
  - cycle after that o_instr_pc=7, o_instr=0x1007;
  - pcs 3 and 4 are never presented again.
- i_en=0 for 3 cycles mid-stream with i_ready=1:
  - the queue drains to empty and o_imem_addr is frozen;
  - re-enable: fetching resumes at the next sequential pc.
- Assert i_rst_n=0 asynchronously mid-clock with the queue full: o_valid=0, o_imem_addr=RESET_PC immediately, before the next edge.
- With IFETCH_BOUNDS_CHECK_EN and NUM_INSTR=11, run from 0 with i_ready=1:
  - pcs 0..10 are delivered, then o_fault=1 and o_imem_addr=11;
  - redirect to 0: o_fault=0 and fetching restarts.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl
// Purpose  : PC sequencer and prefetch queue feeding decode; flushes on redirect.
//            Optional macro IFETCH_BOUNDS_CHECK_EN adds an out-of-range HALT state.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
  parameter int          DEPTH     = 2,
  parameter int          NUM_INSTR = 11,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_fault
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      fetch_pc_q;

  logic pop;
  logic can_fetch;
  logic push;

  assign o_imem_addr = fetch_pc_q;
  assign o_valid     = (count_q != '0);
  assign o_instr     = instr_q[rd_ptr_q];
  assign o_instr_pc  = pc_q[rd_ptr_q];

  assign pop       = o_valid & i_ready;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign can_fetch = i_en & ~i_redirect & ((count_q != FULL_CNT) | pop);

`ifdef IFETCH_BOUNDS_CHECK_EN
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state_q;
  logic   fault_q;
  logic   out_of_range;
  logic   halt;

  assign out_of_range = (fetch_pc_q >= 32'(NUM_INSTR));
  assign push         = (state_q == RUN) & can_fetch & ~out_of_range;
  assign halt         = (state_q == RUN) & can_fetch &  out_of_range;
  assign o_fault      = fault_q;
`else
  logic unused_range_ok;

  assign unused_range_ok = (fetch_pc_q < 32'(NUM_INSTR));
  assign push            = can_fetch;
  assign o_fault         = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
`ifdef IFETCH_BOUNDS_CHECK_EN
      state_q    <= RUN;
      fault_q    <= 1'b0;
`endif
    end else if (i_redirect) begin
      // Redirect wins over push/pop; any handshake this cycle is simply dropped.
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= i_redirect_pc;
`ifdef IFETCH_BOUNDS_CHECK_EN
      state_q    <= RUN;
      fault_q    <= 1'b0;
`endif
    end else begin
      if (push) begin
        instr_q[wr_ptr_q] <= i_imem_data;
        pc_q[wr_ptr_q]    <= fetch_pc_q;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        fetch_pc_q        <= fetch_pc_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
`ifdef IFETCH_BOUNDS_CHECK_EN
      if (halt) begin
        state_q <= HALT;
        fault_q <= 1'b1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_ctrl
// Purpose  : Directed vector table plus corner sequences for instr_fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        valid;
  logic        ready;
  logic        fault;

  int errors = 0;
  int checks = 0;

  instr_fetch_ctrl #(
    .DEPTH     (2),
    .NUM_INSTR (11),
    .RESET_PC  (32'd0)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .o_imem_addr   (imem_addr),
    .i_imem_data   (imem_data),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word n holds 0x1000 + n.
  assign imem_data = 32'h1000 + imem_addr;

  typedef struct {
    bit          rst;
    bit          en;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    bit          efault;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit rd, bit rr, logic [31:0] rp,
                              bit ev, logic [31:0] epc, logic [31:0] ea, bit ef);
    vec_t v;
    v.rst = r; v.en = e; v.rdy = rd; v.redir = rr; v.rpc = rp;
    v.ev = ev; v.epc = epc; v.eaddr = ea; v.efault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " valid"},    {31'd0, valid}, 32'd0);
    chk({tag, " addr"},     imem_addr,      32'd0);
    chk({tag, " instr"},    instr,          32'd0);
    chk({tag, " instr_pc"}, instr_pc,       32'd0);
    chk({tag, " fault"},    {31'd0, fault}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Sequential fetch from reset, ready held high.
    tbl.push_back(mk(1,1,1,0,0, 1,32'd0,32'd1,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd1,32'd2,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd2,32'd3,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd3,32'd4,0));
    // Backpressure fills the queue, then drains in order.
    tbl.push_back(mk(1,1,0,0,0, 1,32'd0,32'd1,0));
    tbl.push_back(mk(0,1,0,0,0, 1,32'd0,32'd2,0));
    tbl.push_back(mk(0,1,0,0,0, 1,32'd0,32'd2,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd1,32'd3,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd2,32'd4,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd3,32'd5,0));
    // Redirect to 7 while queue holds 3,4 and a pop is offered.
    tbl.push_back(mk(0,1,1,1,32'd7, 0,32'd0,32'd7,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd7,32'd8,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd8,32'd9,0));
    // Enable low for 3 cycles: drain and freeze the address.
    tbl.push_back(mk(0,0,1,0,0, 0,32'd0,32'd9,0));
    tbl.push_back(mk(0,0,1,0,0, 0,32'd0,32'd9,0));
    tbl.push_back(mk(0,0,1,0,0, 0,32'd0,32'd9,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd9,32'd10,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd10,32'd11,0));
`ifdef IFETCH_BOUNDS_CHECK_EN
    tbl.push_back(mk(0,1,1,0,0, 0,32'd0,32'd11,1));
    tbl.push_back(mk(0,1,1,0,0, 0,32'd0,32'd11,1));
`else
    tbl.push_back(mk(0,1,1,0,0, 1,32'd11,32'd12,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd12,32'd13,0));
`endif
    tbl.push_back(mk(0,1,1,1,32'd0, 0,32'd0,32'd0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,32'd0,32'd1,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        rst_n = 1'b0;
        #1;
        chk_reset_state($sformatf("v%0d reset", i));
        #1;
        rst_n = 1'b1;
      end
      en = tbl[i].en; ready = tbl[i].rdy;
      redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", i), {31'd0, valid}, {31'd0, tbl[i].ev});
      chk($sformatf("v%0d addr", i),  imem_addr, tbl[i].eaddr);
      chk($sformatf("v%0d fault", i), {31'd0, fault}, {31'd0, tbl[i].efault});
      if (tbl[i].ev) begin
        chk($sformatf("v%0d instr_pc", i), instr_pc, tbl[i].epc);
        chk($sformatf("v%0d instr", i),    instr, 32'h1000 + tbl[i].epc);
      end
    end

    // Fill the queue, then assert reset between clock edges.
    @(negedge clk);
    en = 1'b1; ready = 1'b0; redirect = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("full valid", {31'd0, valid}, 32'd1);
    chk("full addr",  imem_addr, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;

`ifdef IFETCH_BOUNDS_CHECK_EN
    // Redirect straight to an out-of-range address halts without pushing.
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'd20;
    @(posedge clk);
    #1;
    chk("oob redir addr", imem_addr, 32'd20);
    @(negedge clk);
    redirect = 1'b0;
    @(posedge clk);
    #1;
    chk("oob valid", {31'd0, valid}, 32'd0);
    chk("oob fault", {31'd0, fault}, 32'd1);
    chk("oob addr",  imem_addr, 32'd20);
`else
    // Address wraps from the top of the 32-bit space.
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    chk("wrap redir addr",  imem_addr, 32'hFFFF_FFFF);
    chk("wrap redir valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap valid",    {31'd0, valid}, 32'd1);
    chk("wrap instr_pc", instr_pc, 32'hFFFF_FFFF);
    chk("wrap instr",    instr, 32'h0000_0FFF);
    chk("wrap addr",     imem_addr, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
